// File: rtl/mux_bus_arbiter_pkg.sv
// Shared types and constants for the four-requester mux bus arbiter.
package mux_bus_arbiter_pkg;

    localparam int unsigned SelW   = 2;
    localparam int unsigned NumReq = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn  = 2'd1,
        StGap  = 2'd2
    } state_e;

endpackage

// File: rtl/mux_bus_arbiter_rr_pick4.sv
// Combinational round-robin pick: first asserted request scanning from last_owner+1, wrapping.
module rr_pick4
    import mux_bus_arbiter_pkg::*;
(
    input  logic [NumReq-1:0] req,
    input  logic [SelW-1:0]   last_owner,
    output logic              valid,
    output logic [SelW-1:0]   pick
);

    logic [SelW-1:0] idx;

    always_comb begin
        valid = |req;
        pick  = last_owner;
        idx   = '0;
        // Walk from the farthest candidate to the nearest so the nearest match wins.
        for (int k = NumReq; k >= 1; k--) begin
            idx = last_owner + SelW'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

endmodule

// File: rtl/mux_bus_arbiter.sv
// Round-robin owner of a shared dual 4:1 mux: drives select code, active-low enables and grant.
module mux_bus_arbiter
    import mux_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD   = 8,
    parameter int unsigned TURNAROUND = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NumReq-1:0] req,
    output logic [NumReq-1:0] grant,
    output logic              S0,
    output logic              S1,
    output logic              Ea_N,
    output logic              Eb_N,
    output logic              busy
);

    localparam logic [7:0] HoldMax = 8'(MAX_HOLD - 1);

    state_e            state_q, state_d;
    logic [SelW-1:0]   owner_q, owner_d;
    logic [SelW-1:0]   last_owner_q, last_owner_d;
    logic [7:0]        hold_cnt_q, hold_cnt_d;
    logic [NumReq-1:0] grant_q, grant_d;
    logic [SelW-1:0]   sel_q, sel_d;
    logic              en_n_q, en_n_d;
    logic              busy_q, busy_d;

    logic [NumReq-1:0] pick_req;
    logic [SelW-1:0]   pick_last;
    logic              pick_valid;
    logic [SelW-1:0]   pick;
    logic              release_own;

    rr_pick4 u_pick (
        .req        (pick_req),
        .last_owner (pick_last),
        .valid      (pick_valid),
        .pick       (pick)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;
        release_own  = 1'b0;
        pick_req     = req;
        pick_last    = last_owner_q;

        // While owning, the pick only considers the other sources, scanning past the owner.
        if (state_q == StOwn) begin
            pick_req  = req & ~(NumReq'(1) << owner_q);
            pick_last = owner_q;
        end

        unique case (state_q)
            StIdle, StGap: begin
                if (pick_valid) begin
                    state_d    = StOwn;
                    owner_d    = pick;
                    hold_cnt_d = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StOwn: begin
                release_own = !req[owner_q] || ((hold_cnt_q == HoldMax) && pick_valid);
                if (release_own) begin
                    last_owner_d = owner_q;
                    if (TURNAROUND != 0) begin
                        state_d = StGap;
                    end else if (pick_valid) begin
                        owner_d    = pick;
                        hold_cnt_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (hold_cnt_q != HoldMax) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they are derived from the next state.
        grant_d = '0;
        sel_d   = sel_q;
        en_n_d  = 1'b1;
        busy_d  = (state_d != StIdle);
        if (state_d == StOwn) begin
            grant_d = NumReq'(1) << owner_d;
            sel_d   = owner_d;
            en_n_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            last_owner_q <= SelW'(NumReq - 1);
            hold_cnt_q   <= '0;
            grant_q      <= '0;
            sel_q        <= '0;
            en_n_q       <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            grant_q      <= grant_d;
            sel_q        <= sel_d;
            en_n_q       <= en_n_d;
            busy_q       <= busy_d;
        end
    end

    assign grant = grant_q;
    assign S0    = sel_q[1];
    assign S1    = sel_q[0];
    assign Ea_N  = en_n_q;
    assign Eb_N  = en_n_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Bench for mux_bus_arbiter: one instance with a turnaround gap, one with back-to-back handoff.
module tb_mux_bus_arbiter;

    localparam int MaxHold = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;

    logic [3:0] grant_a, grant_b;
    logic       s0_a, s1_a, ea_a, eb_a, busy_a;
    logic       s0_b, s1_b, ea_b, eb_b, busy_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state per instance: owner (-1 when none), last owner, cycles owned, select, in-gap.
    int own_a, last_a, ten_a, sel_a;
    int own_b, last_b, ten_b, sel_b;
    bit gap_a, gap_b;

    always #5 clk = ~clk;

    mux_bus_arbiter #(.MAX_HOLD(MaxHold), .TURNAROUND(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant_a),
        .S0    (s0_a),
        .S1    (s1_a),
        .Ea_N  (ea_a),
        .Eb_N  (eb_a),
        .busy  (busy_a)
    );

    mux_bus_arbiter #(.MAX_HOLD(MaxHold), .TURNAROUND(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant_b),
        .S0    (s0_b),
        .S1    (s1_b),
        .Ea_N  (ea_b),
        .Eb_N  (eb_b),
        .busy  (busy_b)
    );

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input bit ta, input logic [3:0] r, inout int own, inout int last,
                              inout int ten, inout int sel, inout bit gap);
        logic [3:0] others;
        if (own >= 0) begin
            others = r & ~(4'b0001 << own);
            if (!r[own] || (ten >= MaxHold && others != 4'b0000)) begin
                last = own;
                if (ta) begin
                    own = -1;
                    gap = 1'b1;
                end else if (others != 4'b0000) begin
                    own = rr_pick(others, last);
                    ten = 1;
                    sel = own;
                end else begin
                    own = -1;
                end
            end else begin
                ten++;
            end
        end else begin
            gap = 1'b0;
            if (r != 4'b0000) begin
                own = rr_pick(r, last);
                ten = 1;
                sel = own;
            end
        end
    endtask

    task automatic model_reset();
        own_a = -1; last_a = 3; ten_a = 0; sel_a = 0; gap_a = 1'b0;
        own_b = -1; last_b = 3; ten_b = 0; sel_b = 0; gap_b = 1'b0;
    endtask

    function automatic logic [8:0] exp_vec(input int own, input int sel, input bit gap);
        logic [3:0] g;
        logic [1:0] s;
        g = (own >= 0) ? (4'b0001 << own) : 4'b0000;
        s = 2'(sel);
        return {g, s[1], s[0], own < 0, own < 0, (own >= 0) || gap};
    endfunction

    task automatic cmp(input string tag, input logic [8:0] obs, input logic [8:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check(input string tag);
        cmp({tag, "_a"}, {grant_a, s0_a, s1_a, ea_a, eb_a, busy_a}, exp_vec(own_a, sel_a, gap_a));
        cmp({tag, "_b"}, {grant_b, s0_b, s1_b, ea_b, eb_b, busy_b}, exp_vec(own_b, sel_b, gap_b));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step(1'b1, req, own_a, last_a, ten_a, sel_a, gap_a);
        model_step(1'b0, req, own_b, last_b, ten_b, sel_b, gap_b);
        #1;
        check(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic int onehot_idx(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return -1;
    endfunction

    initial begin
        int owners[$];
        logic [3:0] prev_g;
        int cnt;

        req   = 4'b0000;
        reset = 1'b1;
        #2;
        model_reset();
        check("reset");
        @(negedge clk);
        reset = 1'b0;

        // Single request, then asynchronous reset while source 2 owns.
        req = 4'b0100;
        tick("single_grant");
        cmp("single_grant_const", {grant_a, s0_a, s1_a, ea_a, eb_a}, {4'b0100, 4'b1000});
        tick("single_hold");
        do_reset("reset_mid");
        cmp("reset_mid_const", {grant_a, s0_a, s1_a, ea_a, eb_a}, {4'b0000, 4'b0011});
        tick("regrant");
        req = 4'b0000;
        tick("single_drop");
        cmp("single_drop_const", {grant_a, ea_a, eb_a}, {4'b0000, 2'b11});

        // Round-robin fairness: every owner drops after three owned cycles.
        do_reset("reset_rr");
        req    = 4'b1111;
        prev_g = 4'b0000;
        for (int t = 0; t < 24; t++) begin
            tick("rr");
            if (grant_a != 4'b0000 && prev_g == 4'b0000) owners.push_back(onehot_idx(grant_a));
            prev_g = grant_a;
            if (own_a >= 0 && ten_a == 3) req[own_a] = 1'b0;
            else req = 4'b1111;
        end
        cmp("rr_count_ok", 9'(owners.size() >= 5), 9'd1);
        for (int i = 0; i < 5 && i < owners.size(); i++) begin
            cmp("rr_order", 9'(owners[i]), 9'(i % 4));
        end

        // Hold limit with a waiter.
        req = 4'b0000;
        do_reset("reset_hold");
        req = 4'b0010;
        tick("hold_first");
        req = 4'b1010;
        cnt = (grant_a == 4'b0010) ? 1 : 0;
        for (int t = 0; t < 20; t++) begin
            tick("hold_run");
            if (grant_a != 4'b0010) break;
            cnt++;
        end
        cmp("hold_tenure", 9'(cnt), 9'(MaxHold));
        cmp("hold_gap", {grant_a, ea_a}, {4'b0000, 1'b1});
        req = 4'b1000;
        tick("hold_next");
        cmp("hold_next_const", 9'(grant_a), 9'b1000);

        // Hold limit with no waiter, then a late waiter.
        req = 4'b0000;
        do_reset("reset_alone");
        req = 4'b0001;
        for (int t = 0; t < 20; t++) tick("alone");
        cmp("alone_keeps", 9'(grant_a), 9'b0001);
        req = 4'b0101;
        tick("late_waiter");
        cmp("late_release_a", 9'(grant_a), 9'b0000);
        cmp("late_release_b", 9'(grant_b), 9'b0100);

        // Back-to-back handoff on the gapless instance.
        req = 4'b0000;
        do_reset("reset_b2b");
        req = 4'b0011;
        tick("b2b_first");
        tick("b2b_hold");
        cmp("b2b_before", {grant_b, s1_b, ea_b}, {4'b0001, 2'b00});
        req = 4'b0010;
        tick("b2b_switch");
        cmp("b2b_after", {grant_b, s1_b, ea_b}, {4'b0010, 2'b10});

        // Randomized level-sensitive requests.
        req = 4'b0000;
        do_reset("reset_rand");
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 3) == 0) req[$urandom_range(0, 3)] ^= 1'b1;
            if (t == 300) do_reset("reset_rand_mid");
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
